row_bias: RTL and testbench

//  Per-row value-order source for the brute-force solver. Holds a shuffled

---
 rtl/grid_pkg.sv | 22 ++
 rtl/lfsr16.sv | 28 ++
 rtl/row_bias.sv | 124 ++++++++++++
 tb/tb_row_bias.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/grid_pkg.sv
// Shared grid-solver definitions: row length, row_bias FSM states and LFSR taps.
`ifndef GRID_LEN
`define GRID_LEN 9
`endif

package grid_pkg;

  localparam int GRID_LEN = `GRID_LEN;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic {
    SHUF  = 1'b0,
    READY = 1'b1
  } row_bias_state_e;

  // Right-shifting Galois form: feedback taps applied when the outgoing bit is 1.
  function automatic logic [15:0] lfsr_galois_step(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR, reloaded with SEED on reset and free-running otherwise.
module lfsr16
  import grid_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clock,
  input  logic        reset,
  output logic [15:0] q
);

  // An all-zero state would lock the LFSR, so a zero seed is replaced.
  localparam logic [15:0] START = (SEED == 16'h0000) ? 16'h0001 : SEED;

  logic [15:0] r_q;

  // LFSR state register
  always_ff @(posedge clock) begin
    if (reset) begin
      r_q <= START;
    end else begin
      r_q <= lfsr_galois_step(r_q);
    end
  end

  assign q = r_q;

endmodule

// File: rtl/row_bias.sv
// Per-row value-order source: shuffles a permutation of one-hot values and
// answers tile index requests with the permuted value on a shared reply bus.
module row_bias
  import grid_pkg::*;
#(
  parameter int          LEN  = GRID_LEN,
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   reshuffle,
  output logic                   ready,
  input  logic [LEN*(LEN+1)-1:0] tile_rqindex,
  input  logic [LEN-1:0]         tile_update,
  output logic [LEN-1:0]         rowbias,
  output logic                   collision
);

  localparam int             IW  = $clog2(LEN);
  localparam logic [LEN-1:0] ONE = {{(LEN-1){1'b0}}, 1'b1};

  row_bias_state_e r_state;
  logic [IW-1:0]   r_i;
  logic [LEN-1:0]  r_perm [LEN];
  logic [LEN-1:0]  r_rowbias;
  logic            r_collision;

  logic [15:0]     w_lfsr;
  logic [7:0]      w_mod;
  logic [IW-1:0]   w_j;
  logic [LEN-1:0]  w_sel_idx;
  logic            w_hit;
  logic [LEN-1:0]  w_reply;
  logic            w_multi;
  logic            w_unused_sentinel;
  logic            w_unused_bits;

  lfsr16 #(
    .SEED(SEED)
  ) u_lfsr (
    .clock(clock),
    .reset(reset),
    .q    (w_lfsr)
  );

  // Fisher-Yates partner index: low LFSR byte modulo (i+1).
  assign w_mod = w_lfsr[7:0] % ({{(8-IW){1'b0}}, r_i} + 8'd1);
  assign w_j   = w_mod[IW-1:0];

  assign w_multi       = ($countones(tile_update) > 32'sd1);
  assign w_unused_bits = ^{w_lfsr[15:8], w_mod[7:IW]};

  // Priority select: scanning downward leaves the lowest strobing tile's index.
  always_comb begin
    w_sel_idx = {LEN{1'b0}};
    w_hit     = 1'b0;
    for (int t = LEN - 1; t >= 0; t--) begin
      w_sel_idx = tile_update[t] ? tile_rqindex[t*(LEN+1) +: LEN] : w_sel_idx;
      w_hit     = w_hit | tile_update[t];
    end
  end

  // The sentinel bit of each index carries no lookup; it just yields a zero reply.
  always_comb begin
    w_unused_sentinel = 1'b0;
    for (int t = 0; t < LEN; t++) begin
      w_unused_sentinel = w_unused_sentinel | tile_rqindex[t*(LEN+1)+LEN];
    end
  end

  // AND-OR reply mux over the permutation entries
  always_comb begin
    w_reply = {LEN{1'b0}};
    for (int k = 0; k < LEN; k++) begin
      w_reply = w_reply | (r_perm[k] & {LEN{w_sel_idx[k]}});
    end
  end

  // Shuffle/serve FSM with permutation store and registered reply outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= SHUF;
      r_i         <= IW'(LEN - 1);
      r_rowbias   <= {LEN{1'b0}};
      r_collision <= 1'b0;
      for (int k = 0; k < LEN; k++) begin
        r_perm[k] <= ONE << k;
      end
    end else begin
      r_collision <= (r_state == READY) && w_multi;
      case (r_state)
        SHUF: begin
          // When j == i both writes carry the same value, so no special case.
          r_perm[r_i] <= r_perm[w_j];
          r_perm[w_j] <= r_perm[r_i];
          r_i         <= r_i - {{(IW-1){1'b0}}, 1'b1};
          r_rowbias   <= {LEN{1'b0}};
          if (r_i == {{(IW-1){1'b0}}, 1'b1}) begin
            r_state <= READY;
          end
        end
        READY: begin
          if (reshuffle) begin
            r_state   <= SHUF;
            r_i       <= IW'(LEN - 1);
            r_rowbias <= {LEN{1'b0}};
          end else if (w_hit) begin
            r_rowbias <= w_reply;
          end
        end
        default: begin
          r_state   <= SHUF;
          r_i       <= IW'(LEN - 1);
          r_rowbias <= {LEN{1'b0}};
        end
      endcase
    end
  end

  assign ready     = (r_state == READY);
  assign rowbias   = r_rowbias;
  assign collision = r_collision;

endmodule

// File: tb/tb_row_bias.sv
// Scoreboard bench for row_bias (LEN=9): a driver pushes the expected
// post-edge outputs from a behavioural model, a monitor pops and compares.
module tb_row_bias;

  localparam int          LEN  = 9;
  localparam logic [15:0] SEED = 16'hACE1;

  logic         clock;
  logic         reset;
  logic         reshuffle;
  logic         ready;
  logic [89:0]  tile_rqindex;
  logic [8:0]   tile_update;
  logic [8:0]   rowbias;
  logic         collision;

  row_bias #(
    .LEN (LEN),
    .SEED(SEED)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .reshuffle   (reshuffle),
    .ready       (ready),
    .tile_rqindex(tile_rqindex),
    .tile_update (tile_update),
    .rowbias     (rowbias),
    .collision   (collision)
  );

  typedef struct {
    logic       rdy;
    logic [8:0] rb;
    logic       coll;
    logic       acc;
  } exp_t;

  exp_t sb[$];

  int         n_vec  = 0;
  int         n_miss = 0;
  logic [8:0] acc_or;

  // reference model state
  logic       m_ready;
  int         m_i;
  logic [8:0] m_perm [9];
  logic [15:0] m_lfsr;
  logic [8:0] m_rb;
  logic       m_coll;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic logic [89:0] rq_bit(input int t, input int k);
    logic [89:0] v;
    v = '0;
    v[t*10+k] = 1'b1;
    return v;
  endfunction

  // Applies one cycle of stimulus and pushes the outputs expected after the edge.
  task automatic step(input logic rst, input logic resh, input logic [8:0] upd,
                      input logic [89:0] rq, input logic acc);
    exp_t       e;
    logic       ncoll;
    logic [8:0] tmp;
    logic [8:0] rb;
    int         j;
    int         t;
    @(negedge clock);
    reset        = rst;
    reshuffle    = resh;
    tile_update  = upd;
    tile_rqindex = rq;
    if (rst) begin
      m_ready = 1'b0;
      m_i     = 8;
      for (int k = 0; k < 9; k++) m_perm[k] = 9'h001 << k;
      m_lfsr  = SEED;
      m_rb    = 9'h000;
      m_coll  = 1'b0;
    end else begin
      ncoll = m_ready && ($countones(upd) > 1);
      if (!m_ready) begin
        j = int'(m_lfsr[7:0]) % (m_i + 1);
        tmp = m_perm[m_i];
        m_perm[m_i] = m_perm[j];
        m_perm[j] = tmp;
        if (m_i == 1) m_ready = 1'b1;
        m_i = m_i - 1;
        m_rb = 9'h000;
      end else if (resh) begin
        m_ready = 1'b0;
        m_i = 8;
        m_rb = 9'h000;
      end else if (upd != 9'h000) begin
        t = 0;
        for (int s = 8; s >= 0; s--) if (upd[s]) t = s;
        rb = 9'h000;
        for (int k = 0; k < 9; k++) if (rq[t*10+k]) rb = rb | m_perm[k];
        m_rb = rb;
      end
      m_coll = ncoll;
      m_lfsr = {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    end
    e.rdy  = m_ready;
    e.rb   = m_rb;
    e.coll = m_coll;
    e.acc  = acc;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) step(1'b0, 1'b0, 9'h000, '0, 1'b0);
  endtask

  // Probes every permutation entry through a different tile each time.
  task automatic sweep();
    acc_or = 9'h000;
    for (int k = 0; k < 9; k++) step(1'b0, 1'b0, 9'h001 << k, rq_bit(k, k), 1'b1);
    idle(1);
    n_vec++;
    if (acc_or !== 9'h1FF) begin
      n_miss++;
      $display("FAIL perm_cover: OR of replies %h, required 1ff", acc_or);
    end
  endtask

  // Monitor: compare the DUT outputs after each edge against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_vec++;
        if (ready !== e.rdy || rowbias !== e.rb || collision !== e.coll) begin
          n_miss++;
          $display("FAIL vec%0d: ready=%b rowbias=%h collision=%b, required ready=%b rowbias=%h collision=%b",
                   n_vec, ready, rowbias, collision, e.rdy, e.rb, e.coll);
        end
        if (e.acc) acc_or = acc_or | rowbias;
      end
    end
  end

  initial begin
    reset        = 1'b1;
    reshuffle    = 1'b0;
    tile_update  = 9'h000;
    tile_rqindex = '0;
    acc_or       = 9'h000;

    // reset, then the 8-step shuffle; ready must rise on the 8th edge
    step(1'b1, 1'b0, 9'h000, '0, 1'b0);
    step(1'b1, 1'b0, 9'h000, '0, 1'b0);
    step(1'b0, 1'b0, 9'h1FF, rq_bit(0, 0) | rq_bit(1, 1), 1'b0);
    idle(7);
    idle(1);
    sweep();

    // single tile 2 asking for index 3
    step(1'b0, 1'b0, 9'b000000100, rq_bit(2, 3), 1'b0);
    idle(2);
    // sentinel request from tile 5
    step(1'b0, 1'b0, 9'b000100000, rq_bit(5, 9), 1'b0);
    // collision: tiles 1 and 4, tile 1 wins
    step(1'b0, 1'b0, 9'b000010010, rq_bit(1, 0) | rq_bit(4, 6), 1'b0);
    idle(1);
    step(1'b0, 1'b0, 9'b100000001, rq_bit(0, 8) | rq_bit(8, 2), 1'b0);

    // reshuffle beats a simultaneous update; requests ignored while shuffling
    step(1'b0, 1'b1, 9'b000000001, rq_bit(0, 4), 1'b0);
    step(1'b0, 1'b1, 9'b000000011, rq_bit(0, 4) | rq_bit(1, 5), 1'b0);
    idle(7);
    idle(1);
    sweep();

    // reset mid-shuffle at i=4 restarts from identity and the seed
    step(1'b1, 1'b0, 9'h000, '0, 1'b0);
    step(1'b0, 1'b0, 9'h000, '0, 1'b0);
    idle(3);
    step(1'b1, 1'b0, 9'h000, '0, 1'b0);
    idle(8);
    sweep();

    idle(2);
    @(negedge clock);
    n_vec++;
    if (sb.size() != 0) begin
      n_miss++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
